// File: rtl/pq_expiry_pop.sv
// Pops expired heads from the timestamp priority queue and presents them,
// along with their lateness against a free-running time base, on an event port.
module pq_expiry_pop #(
    parameter int DW      = 32,
    parameter int TW      = 16,
    parameter int POP_LAT = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic          tick_i,
    output logic [TW-1:0] time_o,
    input  logic          peek_vld_i,
    input  logic [DW-1:0] peek_data_i,
    input  logic          pop_rdy_i,
    output logic          pop_o,
    input  logic [DW-1:0] data_i,
    output logic          evt_vld_o,
    input  logic          evt_rdy_i,
    output logic [DW-1:0] evt_data_o,
    output logic [TW-1:0] evt_lag_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [2:0] LAT_INIT = 3'(POP_LAT);

    state_t          state_r;
    logic [2:0]      cnt_r;
    logic [TW-1:0]   time_r;
    logic            evt_vld_r;
    logic [DW-1:0]   evt_data_r;
    logic [TW-1:0]   evt_lag_r;
    logic [TW-1:0]   peek_diff_s;
    logic            expired_s;
    logic            pop_s;

    // Modular distance from a queue word's timestamp up to the time base.
    function automatic logic [TW-1:0] ts_diff(input logic [TW-1:0] now,
                                               input logic [DW-1:0] word);
        ts_diff = now - word[TW-1:0];
    endfunction

    // Expiry decision on the same-cycle peek; pop is only issued from IDLE.
    always_comb begin
        peek_diff_s = ts_diff(time_r, peek_data_i);
        expired_s   = peek_vld_i & ~peek_diff_s[TW-1];
        pop_s       = 1'b0;
        if (rst_ni && (state_r == IDLE)) begin
            pop_s = en_i & expired_s & pop_rdy_i;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Free-running time base, independent of en_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            time_r <= '0;
        end else if (tick_i) begin
            time_r <= time_r + {{(TW-1){1'b0}}, 1'b1};
        end else begin
            time_r <= time_r;
        end
    end

    // Pop/wait/hold sequencer; lag uses the pre-increment time of the capture cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= IDLE;
            cnt_r      <= 3'd0;
            evt_vld_r  <= 1'b0;
            evt_data_r <= '0;
            evt_lag_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        cnt_r   <= LAT_INIT;
                        state_r <= WAIT;
                    end else begin
                        cnt_r   <= 3'd0;
                    end
                end
                WAIT: begin
                    if (cnt_r <= 3'd1) begin
                        cnt_r      <= 3'd0;
                        evt_data_r <= data_i;
                        evt_lag_r  <= ts_diff(time_r, data_i);
                        evt_vld_r  <= 1'b1;
                        state_r    <= HOLD;
                    end else begin
                        cnt_r <= cnt_r - 3'd1;
                    end
                end
                HOLD: begin
                    if (evt_rdy_i) begin
                        evt_vld_r <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        evt_vld_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= 3'd0;
                    evt_vld_r <= 1'b0;
                end
            endcase
        end
    end

    assign time_o     = time_r;
    assign pop_o      = pop_s;
    assign evt_vld_o  = evt_vld_r;
    assign evt_data_o = evt_data_r;
    assign evt_lag_o  = evt_lag_r;

endmodule

// File: doc/pq_expiry_pop.md
Name: pq_expiry_pop

Overview:
- Downstream consumer of the timestamp priority queue (pq).
- Keeps a free-running time base and watches the queue head through the pq peek interface.
- When the head's timestamp has expired, pops it from the pq and presents it on a valid/ready event port, together with its lateness.
- Sits between pq and the event-dispatch logic; it is the only driver of pq pop_i.

Parameters:
- DW, 32, pq data word width; must equal the pq DW.
- TW, 16, time/timestamp width; timestamp is data[TW-1:0]; TW <= DW.
- POP_LAT, 1, cycles from pop_o asserted to pq data_o valid; legal range 1..4.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- en_i  in  1  enable; 0 blocks issue of new pops.
- tick_i  in  1  time-base increment strobe.
- time_o  out  TW  current time base.
- peek_vld_i  in  1  from pq peek_vld_o.
- peek_data_i  in  DW  from pq peek_data_o.
- pop_rdy_i  in  1  from pq pop_rdy_o.
- pop_o  out  1  to pq pop_i; one-cycle pulse.
- data_i  in  DW  from pq data_o.
- evt_vld_o  out  1  event valid.
- evt_rdy_i  in  1  event ready.
- evt_data_o  out  DW  popped entry.
- evt_lag_o  out  TW  (time at capture - timestamp) mod 2^TW.

Behaviour:
- Reset (async assert, sync release at clock edge):
  - time_o = 0, pop_o = 0, evt_vld_o = 0, evt_data_o = 0, evt_lag_o = 0, state = IDLE, latency counter = 0.
  - Reset mid-operation abandons any in-flight pop and any held event.
- Time base:
  - time_o increments by 1 on every cycle with tick_i = 1.
  - Wraps 2^TW-1 -> 0; not affected by en_i.
  - All comparisons use the registered (pre-increment) value.
- Expiry test (combinational): diff = (time_o - peek_data_i[TW-1:0]) mod 2^TW; expired = peek_vld_i & ~diff[TW-1].
  - A timestamp equal to time_o is expired.
  - Timestamps up to 2^(TW-1)-1 behind time_o are expired.
  - Timestamps in the future (diff MSB = 1) are not.
- FSM, IDLE:
  - If en_i & expired & pop_rdy_i: pop_o = 1 for exactly this cycle, load counter = POP_LAT, go to WAIT.
  - Otherwise pop_o = 0.
  - IDLE is only entered with the event register empty, so there are never two outstanding pops.
- FSM, WAIT:
  - pop_o = 0; counter decrements each cycle.
  - In the cycle counter reaches 0 (POP_LAT cycles after pop_o): capture data_i into evt_data_o and (time_o - data_i[TW-1:0]) mod 2^TW into evt_lag_o, set evt_vld_o = 1, go to HOLD.
  - en_i deassertion does not cancel WAIT.
- FSM, HOLD:
  - evt_vld_o, evt_data_o and evt_lag_o stay stable until the evt_vld_o & evt_rdy_i handshake.
  - On the handshake edge, evt_vld_o clears and the FSM returns to IDLE.
  - No pop is issued in the handshake cycle; the earliest next pop is the following cycle.
  - Peak throughput is one event per POP_LAT+2 cycles.
- Peek/drop race: the decision uses same-cycle peek values only.
  - If the head is dropped in the same cycle as pop_o, the block forwards whatever the pq returns on data_i.
  - Lag is computed from the returned data, not the peeked data.
- Empty pq: peek_vld_i = 0 means no pop.
- pop_rdy_i = 0 means no pop; retried each cycle while in IDLE.
- evt_rdy_i held 0 stalls the block indefinitely in HOLD; the pq is never popped while an event is held.
- tick_i in the capture cycle: lag uses the pre-increment time.

Test Plan:
- Reset, then tick 5 times; pq head ts = 7 → no pop while time_o < 7. At time_o = 7, pop_o pulses once; with POP_LAT=1, data captured one cycle later; evt_vld_o = 1, evt_lag_o = 0.
- Wrap: TW=16, time_o = 0x0002, head ts = 0xFFFE → expired, evt_lag_o = 4. Head ts = 0x0005 → not popped.
- Backpressure: evt_rdy_i = 0 for 10 cycles with expired head → exactly one pop_o, evt_data_o stable 10 cycles. After rdy = 1, the next pop occurs no earlier than the cycle after the handshake.
- Gating: en_i = 0 or pop_rdy_i = 0 with expired head → pop_o stays 0. When both are 1, pop occurs in that cycle. Dropping en_i during WAIT still yields the event.
- POP_LAT=3: pop_o at cycle N → capture at N+3. Assert rst_ni low at N+1 → evt_vld_o stays 0, state IDLE, time_o = 0.
- Back-to-back: 3 entries all expired, evt_rdy_i = 1 → 3 events in ascending timestamp order, pop_o spacing = POP_LAT+2 cycles.
